// File: rtl/level_shaper_pkg.sv
// Shared state encoding, SET_HI divisor list and parameter defaults for the
// level shaper.
package level_shaper_pkg;

  typedef enum logic [2:0] {
    IDLE,
    KICK_HI,
    SET_HI,
    KICK_LO,
    SET_LO
  } state_e;

  localparam int W_DEF        = 12;
  localparam int L_MAX_DEF    = 500;
  localparam int HOLD_DEF     = 12288;
  localparam int STEP_DIV_DEF = 10;

  // Candidate divisors for the SET_HI level, tried in order.
  localparam int K_NUM = 5;

  function automatic int k_div(input int idx);
    case (idx)
      0:       return 2;
      1:       return 3;
      2:       return 4;
      3:       return 5;
      default: return 10;
    endcase
  endfunction

endpackage

// File: rtl/level_shaper_bit_sync_edge.sv
// Two-flop synchronizer for an asynchronous bit, with one-cycle rise/fall
// pulses taken from the synchronized value and its delayed copy.
module bit_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q, sync2_q, dly_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      dly_q   <= 1'b0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
      dly_q   <= sync2_q;
    end
  end

  assign rise_o = sync2_q & ~dly_q;
  assign fall_o = ~sync2_q & dly_q;

endmodule

// File: rtl/level_shaper.sv
// Level shaper: manual up/down level steps, plus kick-then-settle shaping of
// the output level on each data edge while the link is transmitting.
module level_shaper
  import level_shaper_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int L_MAX    = L_MAX_DEF,
  parameter int HOLD     = HOLD_DEF,
  parameter int STEP_DIV = STEP_DIV_DEF
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         data_start_i,
  input  logic         data_trans_i,
  input  logic         data_rec_i,
  input  logic         d_i,
  input  logic         step_vld_i,
  input  logic         step_up_i,
  input  logic [W-1:0] l_i,
  input  logic [W-1:0] l_def_i,
  output logic [W-1:0] l_adj_o,
  output logic         kick_o,
  output logic         step_ack_o
);

  localparam int CW = $clog2(HOLD + 1);

  typedef logic [W-1:0]  lvl_t;
  typedef logic [W:0]    step_t;
  typedef logic [W+1:0]  wide_t;
  typedef logic [CW-1:0] cnt_t;

  localparam lvl_t  LMAX_L = lvl_t'(L_MAX);
  localparam step_t LMAX_S = step_t'(L_MAX);
  localparam wide_t LMAX_W = wide_t'(L_MAX);
  localparam cnt_t  CNT_LD = cnt_t'(HOLD - 1);

  state_e state_q, state_d;
  cnt_t   cnt_q, cnt_d;
  lvl_t   l_adj_q, l_adj_d;
  logic   kick_q, kick_d;
  logic   step_ack_q, step_ack_d;

  logic   rise, fall, tx;
  lvl_t   ld, step_lvl, set_hi_lvl, set_lo_lvl;
  step_t  l_s, step_q_s, step_up_s;
  wide_t  ld_w, cand_w, set_hi_w, set_lo_w;

  bit_sync_edge u_sync (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (d_i),
    .rise_o (rise),
    .fall_o (fall)
  );

  assign tx = data_start_i & data_trans_i & ~data_rec_i;
  assign ld = (l_def_i > LMAX_L) ? LMAX_L : l_def_i;

  // Extra headroom bit keeps l + l/STEP_DIV from wrapping before the clamp.
  always_comb begin
    l_s       = {1'b0, l_i};
    step_q_s  = l_s / step_t'(STEP_DIV);
    step_up_s = l_s + step_q_s;
    if (step_up_s > LMAX_S) step_up_s = LMAX_S;
    step_lvl  = step_up_i ? lvl_t'(step_up_s) : lvl_t'(l_s - step_q_s);
  end

  // Loop runs backwards so the earliest qualifying divisor wins.
  always_comb begin
    ld_w     = {2'b00, ld};
    cand_w   = '0;
    set_hi_w = LMAX_W;
    for (int i = K_NUM - 1; i >= 0; i--) begin
      cand_w = ld_w + ld_w / wide_t'(k_div(i));
      if (cand_w < LMAX_W) set_hi_w = cand_w;
    end
    if ((LMAX_W - ld_w) < ld_w / wide_t'(5))
      set_lo_w = (ld_w << 1) - LMAX_W;
    else
      set_lo_w = ld_w / wide_t'(3);
    set_hi_lvl = lvl_t'(set_hi_w);
    set_lo_lvl = lvl_t'(set_lo_w);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    l_adj_d    = l_adj_q;
    step_ack_d = 1'b0;

    if (step_vld_i) begin
      state_d    = IDLE;
      cnt_d      = '0;
      l_adj_d    = step_lvl;
      step_ack_d = 1'b1;
    end else if (tx) begin
      if (rise) begin
        state_d = KICK_HI;
        cnt_d   = CNT_LD;
        l_adj_d = LMAX_L;
      end else if (fall) begin
        state_d = KICK_LO;
        cnt_d   = CNT_LD;
        l_adj_d = '0;
      end else begin
        case (state_q)
          IDLE: l_adj_d = ld;
          KICK_HI: begin
            if (cnt_q == '0) begin
              state_d = SET_HI;
              l_adj_d = set_hi_lvl;
            end else begin
              cnt_d = cnt_q - cnt_t'(1);
            end
          end
          KICK_LO: begin
            if (cnt_q == '0) begin
              state_d = SET_LO;
              l_adj_d = set_lo_lvl;
            end else begin
              cnt_d = cnt_q - cnt_t'(1);
            end
          end
          default: ;
        endcase
      end
    end else begin
      state_d = IDLE;
      cnt_d   = '0;
      if (data_start_i)        l_adj_d = ld;
      else if (l_adj_q == '0)  l_adj_d = l_i;
    end

    kick_d = (state_d == KICK_HI) || (state_d == KICK_LO);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      l_adj_q    <= l_i;
      kick_q     <= 1'b0;
      step_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      l_adj_q    <= l_adj_d;
      kick_q     <= kick_d;
      step_ack_q <= step_ack_d;
    end
  end

  assign l_adj_o    = l_adj_q;
  assign kick_o     = kick_q;
  assign step_ack_o = step_ack_q;

endmodule
